approx_csa_row: RTL

Parametrised, pipelined carry-save row of 3:2 compressor cells for the approximate multiplier's partial-product reduction tree. Each bit position is either an exact full adder or an OR-AND approximate cell (sum = a|b|d, carry = a&b). The split point is selectable per transaction at run time. A two-stage elastic valid/ready pipeline carries each transaction, and a saturating error monitor counts transactions whose approximate result differs from the exact sum.

---
 rtl/approx_mult_pkg.sv | 18 +
 rtl/approx_cell_sel.sv | 16 +
 rtl/approx_csa_row.sv | 92 +++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and cell functions for the approximate multiplier reduction tree.
// Each cell function returns {carry, sum}.
package approx_mult_pkg;
  localparam int ROW_W_DEF = 16;

  typedef enum logic {
    CELL_EXACT  = 1'b0,
    CELL_OR_AND = 1'b1
  } cell_kind_e;

  function automatic logic [1:0] or_and_fn(input logic a, input logic b, input logic d);
    return {a & b, a | b | d};
  endfunction

  function automatic logic [1:0] full_add_fn(input logic a, input logic b, input logic d);
    return {(a & b) | (a & d) | (b & d), a ^ b ^ d};
  endfunction
endpackage

// File: rtl/approx_cell_sel.sv
// One-bit 3:2 compressor.
// The kind input picks between an exact full adder and the OR-AND approximation.
module approx_cell_sel
  import approx_mult_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       d,
  input  cell_kind_e kind,
  output logic       s,
  output logic       c
);
  always_comb begin
    {c, s} = (kind == CELL_OR_AND) ? or_and_fn(a, b, d) : full_add_fn(a, b, d);
  end
endmodule

// File: rtl/approx_csa_row.sv
// Two-stage elastic carry-save row with a run-time exact/approximate split point.
// Also carries a saturating error counter for approximate results that differ from the exact sum.
module approx_csa_row
  import approx_mult_pkg::*;
#(
  parameter int W     = ROW_W_DEF,
  parameter int ERR_W = 16,
  parameter int AW    = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     d,
  input  logic [AW-1:0]    approx_lsbs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     sum,
  output logic [W-1:0]     carry,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             err_clr
);
  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  d;
    logic [AW-1:0] lsbs;
  } req_t;

  localparam logic [AW-1:0] LSBS_MAX = AW'(W);

  req_t         s1;
  logic [2:1]   vld_pipe;
  logic         s2_load;
  logic [W-1:0] s_comb, c_comb;
  logic [W+1:0] csa_val, ref_val;

  assign out_valid = vld_pipe[2];
  assign s2_load   = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || s2_load;

  for (genvar i = 0; i < W; i++) begin : g_cell
    cell_kind_e kind;
    assign kind = (AW'(i) < s1.lsbs) ? CELL_OR_AND : CELL_EXACT;
    approx_cell_sel u_cell (
      .a    (s1.a[i]),
      .b    (s1.b[i]),
      .d    (s1.d[i]),
      .kind (kind),
      .s    (s_comb[i]),
      .c    (c_comb[i])
    );
  end

  // Both sides widened to W+2 so neither the carry shift nor the 3-operand sum can overflow.
  assign csa_val = {2'b00, s_comb} + {1'b0, c_comb, 1'b0};
  assign ref_val = {2'b00, s1.a} + {2'b00, s1.b} + {2'b00, s1.d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      sum      <= '0;
      carry    <= '0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (in_valid && in_ready) begin
        s1.a    <= a;
        s1.b    <= b;
        s1.d    <= d;
        s1.lsbs <= (approx_lsbs > LSBS_MAX) ? LSBS_MAX : approx_lsbs;
      end
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          sum      <= s_comb;
          carry    <= c_comb;
          mismatch <= (csa_val != ref_val);
        end
      end
      if (err_clr)
        err_cnt <= '0;
      else if (out_valid && out_ready && mismatch && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end
endmodule
